// File: rtl/wb_gpio_slave_if.sv
// Wishbone classic bus bundle for the GPIO slave: request signals from the
// master, response and read data back from the slave.
`timescale 1ns/1ps
interface wb_gpio_slave_if;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_I;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic        ACK_O;
    logic        ERR_O;
    logic        RTY_O;

    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O, ERR_O, RTY_O
    );

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O, ERR_O, RTY_O
    );
endinterface

// File: rtl/wb_gpio_slave.sv
// Wishbone classic GPIO slave: data-in/out, direction, edge-triggered
// interrupts with per-bit polarity and write-1-to-clear status.
// Optional feature macro: WB_GPIO_TOGGLE_EN (index 6 becomes a write-only
// TOGGLE register; otherwise index 6 is unmapped and answers with ERR_O).
`timescale 1ns/1ps
module wb_gpio_slave #(
    parameter int GPIO_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    wb_gpio_slave_if.slave        wb,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DONE} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    state_t state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       latch_en;

    // latched request
    logic [2:0]  idx_reg;
    logic        we_reg;
    logic [3:0]  sel_reg;
    logic [31:0] dat_reg;

    // request as seen on the commit edge: straight from the bus when the
    // response follows the sampling edge directly, else the latched copy
    logic [2:0]  req_idx;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        req_err;
    logic        commit;
    logic        wr;

    logic [GPIO_WIDTH-1:0] data_out_reg, data_out_next;
    logic [GPIO_WIDTH-1:0] dir_reg, dir_next;
    logic [GPIO_WIDTH-1:0] irq_en_reg, irq_en_next;
    logic [GPIO_WIDTH-1:0] irq_stat_reg, irq_stat_next;
    logic [GPIO_WIDTH-1:0] edge_reg, edge_next;
    logic [GPIO_WIDTH-1:0] sync1_reg, sync2_reg, hist_reg;
    logic [GPIO_WIDTH-1:0] edge_hit;
    logic [GPIO_WIDTH-1:0] lane_mask;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] rd_value;

    logic        irq_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] dat_o_reg;

    // State register and wait-state counter
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: accept, optional wait with abort, one response cycle,
    // then a DONE cycle so a still-high STB is not taken as a new access
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wb.CYC_I && wb.STB_I) begin
                    latch_en = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(wb.CYC_I && wb.STB_I)) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 3'd1) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_RESP: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the request when it is accepted
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            idx_reg <= 3'd0;
            we_reg  <= 1'b0;
            sel_reg <= 4'd0;
            dat_reg <= 32'd0;
        end else if (latch_en) begin
            idx_reg <= wb.ADR_I[4:2];
            we_reg  <= wb.WE_I;
            sel_reg <= wb.SEL_I;
            dat_reg <= wb.DAT_I;
        end
    end

    assign req_idx = (state_reg == ST_IDLE) ? wb.ADR_I[4:2] : idx_reg;
    assign req_we  = (state_reg == ST_IDLE) ? wb.WE_I       : we_reg;
    assign req_sel = (state_reg == ST_IDLE) ? wb.SEL_I      : sel_reg;
    assign req_dat = (state_reg == ST_IDLE) ? wb.DAT_I      : dat_reg;

    // RESP is only ever entered from IDLE or WAIT, so this is the ACK edge
    assign commit = (state_next == ST_RESP);

`ifdef WB_GPIO_TOGGLE_EN
    assign req_err = (req_idx == 3'd7) || (req_we && req_idx == 3'd0);
`else
    assign req_err = (req_idx == 3'd7) || (req_idx == 3'd6) ||
                     (req_we && req_idx == 3'd0);
`endif

    assign wr    = commit && req_we && !req_err;
    assign wdata = req_dat[GPIO_WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_lane
            assign lane_mask[gi] = req_sel[gi/8];
        end
    endgenerate

    // Edge detect on the synchronized input against its one-cycle history
    assign edge_hit = (edge_reg & sync2_reg & ~hist_reg) |
                      (~edge_reg & ~sync2_reg & hist_reg);

    // Register file next values; edge set overrides a simultaneous W1C
    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        irq_en_next   = irq_en_reg;
        edge_next     = edge_reg;
        irq_stat_next = irq_stat_reg;
        if (wr) begin
            case (req_idx)
                3'd1: data_out_next = (data_out_reg & ~lane_mask) | (wdata & lane_mask);
                3'd2: dir_next      = (dir_reg & ~lane_mask)      | (wdata & lane_mask);
                3'd3: irq_en_next   = (irq_en_reg & ~lane_mask)   | (wdata & lane_mask);
                3'd4: irq_stat_next = irq_stat_reg & ~(wdata & lane_mask);
                3'd5: edge_next     = (edge_reg & ~lane_mask)     | (wdata & lane_mask);
`ifdef WB_GPIO_TOGGLE_EN
                3'd6: data_out_next = data_out_reg ^ (wdata & lane_mask);
`endif
                default: ;
            endcase
        end
        irq_stat_next = irq_stat_next | edge_hit;
    end

    // Register file storage
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            data_out_reg <= '0;
            dir_reg      <= '0;
            irq_en_reg   <= '0;
            irq_stat_reg <= '0;
            edge_reg     <= '0;
        end else begin
            data_out_reg <= data_out_next;
            dir_reg      <= dir_next;
            irq_en_reg   <= irq_en_next;
            irq_stat_reg <= irq_stat_next;
            edge_reg     <= edge_next;
        end
    end

    // Two-flop synchronizer plus history flop for edge detection
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            hist_reg  <= '0;
        end else begin
            sync1_reg <= gpio_i;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    // Registered level interrupt from enabled pending status
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(irq_stat_reg & irq_en_reg);
        end
    end

    // Read mux; TOGGLE and unmapped indices read as zero
    always_comb begin
        rd_value = '0;
        case (req_idx)
            3'd0: rd_value = sync2_reg;
            3'd1: rd_value = data_out_reg;
            3'd2: rd_value = dir_reg;
            3'd3: rd_value = irq_en_reg;
            3'd4: rd_value = irq_stat_reg;
            3'd5: rd_value = edge_reg;
            default: rd_value = '0;
        endcase
    end

    // Bus response: ACK/ERR and read data live for exactly the RESP cycle
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            dat_o_reg <= 32'd0;
        end else if (commit) begin
            ack_reg   <= !req_err;
            err_reg   <= req_err;
            dat_o_reg <= (!req_we && !req_err) ? 32'(rd_value) : 32'd0;
        end else begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            dat_o_reg <= 32'd0;
        end
    end

    assign wb.ACK_O = ack_reg;
    assign wb.ERR_O = err_reg;
    assign wb.RTY_O = 1'b0;
    assign wb.DAT_O = dat_o_reg;
    assign gpio_o   = data_out_reg;
    assign gpio_oe  = dir_reg;
    assign irq_o    = irq_reg;

    // Address bits outside [4:2] and lanes above GPIO_WIDTH are don't-care
    logic unused_bits;
    assign unused_bits = &{1'b0, wb.ADR_I[31:5], wb.ADR_I[1:0], req_dat, req_sel};

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Self-checking bench for wb_gpio_slave: DUT A (32 pins, no wait states)
// carries the functional tests; DUT B (12 pins, 3 wait states) covers
// latency, width masking and reset in the middle of a waited access.
`timescale 1ns/1ps
module tb_wb_gpio_slave;
    localparam int WA  = 32;
    localparam int WB  = 12;
    localparam int WSB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_gpio_slave_if bus_a();
    wb_gpio_slave_if bus_b();

    logic [31:0]   gpio_in;
    logic [WA-1:0] gpo_a, oe_a;
    logic [WB-1:0] gpo_b, oe_b;
    logic          irq_a, irq_b;

    wb_gpio_slave #(.GPIO_WIDTH(WA), .WAIT_STATES(0)) dut_a (
        .CLK_I(clk), .RST_I(rst), .wb(bus_a),
        .gpio_i(gpio_in[WA-1:0]), .gpio_o(gpo_a), .gpio_oe(oe_a), .irq_o(irq_a)
    );

    wb_gpio_slave #(.GPIO_WIDTH(WB), .WAIT_STATES(WSB)) dut_b (
        .CLK_I(clk), .RST_I(rst), .wb(bus_b),
        .gpio_i(gpio_in[WB-1:0]), .gpio_o(gpo_b), .gpio_oe(oe_b), .irq_o(irq_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model of DUT A (full 32 bits) and B's DATA_OUT
    logic [31:0] m_dout, m_dir, m_en, m_stat, m_edge, m_gpio;
    logic [31:0] mb_dout;
    localparam logic [31:0] MASK_B = 32'h0000_0FFF;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int l = 0; l < 4; l++)
            if (sel[l]) r[l*8 +: 8] = new_v[l*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] sel);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = {8{sel[l]}};
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return m_gpio;
            1: return m_dout;
            2: return m_dir;
            3: return m_en;
            4: return m_stat;
            5: return m_edge;
            default: return 32'd0;
        endcase
    endfunction

    // apply a legal register write of DUT A to the model
    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] sel);
        case (idx)
            1: m_dout = lane_merge(m_dout, d, sel);
            2: m_dir  = lane_merge(m_dir, d, sel);
            3: m_en   = lane_merge(m_en, d, sel);
            4: m_stat = m_stat & ~(d & lane_bits(sel));
            5: m_edge = lane_merge(m_edge, d, sel);
            6: m_dout = m_dout ^ (d & lane_bits(sel));
            default: ;
        endcase
    endtask

    task automatic drive(input int which, input logic act, input logic we, input int idx,
                         input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] adr;
        adr = $urandom();
        adr[4:2] = 3'(idx);
        if (which == 0) begin
            bus_a.ADR_I = adr; bus_a.DAT_I = d; bus_a.SEL_I = sel;
            bus_a.WE_I = we; bus_a.STB_I = act; bus_a.CYC_I = act;
        end else begin
            bus_b.ADR_I = adr; bus_b.DAT_I = d; bus_b.SEL_I = sel;
            bus_b.WE_I = we; bus_b.STB_I = act; bus_b.CYC_I = act;
        end
    endtask

    // One complete bus access; lat = negedges from request to response
    task automatic bus_xfer(input int which, input logic we, input int idx,
                            input logic [31:0] wdata, input logic [3:0] sel,
                            output logic [31:0] rdata, output logic ack,
                            output logic err, output int lat);
        logic seen;
        seen = 1'b0; ack = 1'b0; err = 1'b0; rdata = 32'd0; lat = 0;
        @(negedge clk);
        drive(which, 1'b1, we, idx, wdata, sel);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (which == 0 && (bus_a.ACK_O || bus_a.ERR_O)) begin
                seen = 1'b1; ack = bus_a.ACK_O; err = bus_a.ERR_O; rdata = bus_a.DAT_O;
            end else if (which == 1 && (bus_b.ACK_O || bus_b.ERR_O)) begin
                seen = 1'b1; ack = bus_b.ACK_O; err = bus_b.ERR_O; rdata = bus_b.DAT_O;
            end
        end
        drive(which, 1'b0, 1'b0, 0, 32'd0, 4'd0);
        if (!seen) begin
            n_checks++;
            $display("FAIL bus_timeout dut=%0d idx=%0d: no ACK/ERR within 20 cycles", which, idx);
        end
        @(negedge clk);
    endtask

    // change pins and wait until edge status and irq have settled; the model
    // sets a status bit for each pin whose new level matches its EDGE polarity
    task automatic settle_gpio(input logic [31:0] new_v);
        logic [31:0] changed;
        @(negedge clk);
        changed = new_v ^ m_gpio;
        gpio_in = new_v;
        m_stat  = m_stat | (changed & ~(new_v ^ m_edge));
        m_gpio  = new_v;
        repeat (6) @(negedge clk);
    endtask

    task automatic model_reset();
        m_dout = 0; m_dir = 0; m_en = 0; m_stat = 0; m_edge = 0; mb_dout = 0;
        m_gpio = gpio_in;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ack, err; int lat; bit seen_resp;
        rst = 1'b1;
        gpio_in = 32'd0;
        drive(0, 1'b0, 1'b0, 0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus_a.ACK_O, bus_a.ERR_O, bus_a.RTY_O, bus_a.DAT_O, gpo_a, oe_a, irq_a} !== '0)
            $display("FAIL reset_state_a: ack=%b err=%b rty=%b dat=%h gpo=%h oe=%h irq=%b, all required 0",
                     bus_a.ACK_O, bus_a.ERR_O, bus_a.RTY_O, bus_a.DAT_O, gpo_a, oe_a, irq_a);
        else n_pass++;

        // wait-state DUT: latency and width masking
        bus_xfer(1, 1'b1, 1, 32'hFFFF_FFFF, 4'hF, rd, ack, err, lat);
        mb_dout = 32'hFFFF_FFFF & MASK_B;
        n_checks++;
        if (lat !== 1 + WSB || ack !== 1'b1)
            $display("FAIL latency_ws3: lat=%0d ack=%b, required lat=%0d ack=1", lat, ack, 1 + WSB);
        else n_pass++;
        n_checks++;
        if (32'(gpo_b) !== mb_dout)
            $display("FAIL width_mask_gpo_b: got %h required %h", gpo_b, mb_dout);
        else n_pass++;
        bus_xfer(1, 1'b0, 1, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== mb_dout || ack !== 1'b1)
            $display("FAIL readback_b: got %h ack=%b required %h ack=1", rd, ack, mb_dout);
        else n_pass++;

        // reset in the middle of a waited access
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1, 32'd0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_b.ACK_O, bus_b.ERR_O, bus_b.DAT_O, gpo_b, oe_b, irq_b} !== '0)
            $display("FAIL reset_midwait: ack=%b err=%b dat=%h gpo=%h oe=%h irq=%b, all required 0",
                     bus_b.ACK_O, bus_b.ERR_O, bus_b.DAT_O, gpo_b, oe_b, irq_b);
        else n_pass++;
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 0, 32'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen_resp = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_b.ACK_O || bus_b.ERR_O) seen_resp = 1;
        end
        n_checks++;
        if (seen_resp) $display("FAIL abandoned_no_ack: response seen=1 required 0");
        else n_pass++;
        bus_xfer(1, 1'b0, 1, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== mb_dout || ack !== 1'b1)
            $display("FAIL read_after_reset: got %h ack=%b required %h ack=1", rd, ack, mb_dout);
        else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic ack, err; int lat;
        bus_xfer(0, 1'b1, 1, 32'h0000_00A5, 4'b0001, rd, ack, err, lat);
        model_write(1, 32'h0000_00A5, 4'b0001);
        n_checks++;
        if (lat !== 1 || ack !== 1'b1 || err !== 1'b0)
            $display("FAIL latency_ws0: lat=%0d ack=%b err=%b required lat=1 ack=1 err=0", lat, ack, err);
        else n_pass++;
        bus_xfer(0, 1'b1, 1, 32'hFFFF_FFFF, 4'b0010, rd, ack, err, lat);
        model_write(1, 32'hFFFF_FFFF, 4'b0010);
        n_checks++;
        if (gpo_a !== m_dout)
            $display("FAIL byte_lane_gpo: got %h required %h", gpo_a, m_dout);
        else n_pass++;
        bus_xfer(0, 1'b0, 1, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_dout || ack !== 1'b1)
            $display("FAIL byte_lane_read: got %h ack=%b required %h ack=1", rd, ack, m_dout);
        else n_pass++;
        n_checks++;
        if (bus_a.DAT_O !== 32'd0)
            $display("FAIL dat_o_idle: got %h required 0", bus_a.DAT_O);
        else n_pass++;
    endtask

    task automatic test_dir_err();
        logic [31:0] rd; logic ack, err; int lat;
        bus_xfer(0, 1'b1, 2, 32'h0F0F_0F0F, 4'hF, rd, ack, err, lat);
        model_write(2, 32'h0F0F_0F0F, 4'hF);
        n_checks++;
        if (oe_a !== m_dir) $display("FAIL dir_oe: got %h required %h", oe_a, m_dir);
        else n_pass++;
        bus_xfer(0, 1'b1, 0, 32'hDEAD_BEEF, 4'hF, rd, ack, err, lat);
        n_checks++;
        if (err !== 1'b1 || ack !== 1'b0)
            $display("FAIL write_idx0_err: ack=%b err=%b required ack=0 err=1", ack, err);
        else n_pass++;
        bus_xfer(0, 1'b0, 7, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (err !== 1'b1 || ack !== 1'b0 || rd !== 32'd0)
            $display("FAIL read_idx7_err: ack=%b err=%b dat=%h required ack=0 err=1 dat=0", ack, err, rd);
        else n_pass++;
        bus_xfer(0, 1'b0, 2, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_dir || gpo_a !== m_dout)
            $display("FAIL err_no_change: dir=%h gpo=%h required dir=%h gpo=%h", rd, gpo_a, m_dir, m_dout);
        else n_pass++;

        bus_xfer(0, 1'b1, 1, 32'h0000_00FF, 4'hF, rd, ack, err, lat);
        model_write(1, 32'h0000_00FF, 4'hF);
        bus_xfer(0, 1'b1, 6, 32'h0000_0FF0, 4'hF, rd, ack, err, lat);
`ifdef WB_GPIO_TOGGLE_EN
        model_write(6, 32'h0000_0FF0, 4'hF);
        n_checks++;
        if (ack !== 1'b1 || err !== 1'b0 || gpo_a !== m_dout)
            $display("FAIL toggle: ack=%b err=%b gpo=%h required ack=1 err=0 gpo=%h", ack, err, gpo_a, m_dout);
        else n_pass++;
`else
        n_checks++;
        if (ack !== 1'b0 || err !== 1'b1 || gpo_a !== m_dout)
            $display("FAIL idx6_unmapped: ack=%b err=%b gpo=%h required ack=0 err=1 gpo=%h", ack, err, gpo_a, m_dout);
        else n_pass++;
`endif
    endtask

    task automatic test_irq_rise();
        logic [31:0] rd; logic ack, err; int lat;
        bus_xfer(0, 1'b1, 5, 32'h0000_0001, 4'hF, rd, ack, err, lat); model_write(5, 32'h1, 4'hF);
        bus_xfer(0, 1'b1, 3, 32'h0000_0001, 4'hF, rd, ack, err, lat); model_write(3, 32'h1, 4'hF);
        bus_xfer(0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF, rd, ack, err, lat); model_write(4, 32'hFFFF_FFFF, 4'hF);
        // rise on pin 0: irq must appear on the fourth cycle, not earlier
        @(negedge clk);
        gpio_in[0] = 1'b1;
        m_gpio[0] = 1'b1;
        m_stat[0] = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL irq_early: irq=%b after 3 cycles required 0", irq_a);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (irq_a !== 1'b1) $display("FAIL irq_4cyc: irq=%b after 4 cycles required 1", irq_a);
        else n_pass++;
        bus_xfer(0, 1'b0, 4, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_stat) $display("FAIL irq_stat_rise: got %h required %h", rd, m_stat);
        else n_pass++;
        bus_xfer(0, 1'b1, 4, 32'h0000_0001, 4'hF, rd, ack, err, lat); model_write(4, 32'h1, 4'hF);
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL w1c_irq_clear: irq=%b required 0", irq_a);
        else n_pass++;
        settle_gpio(m_gpio & ~32'h1);
        // new rise whose status-set edge coincides with a W1C commit
        @(negedge clk);
        gpio_in[0] = 1'b1;
        m_gpio[0] = 1'b1;
        @(negedge clk);
        bus_xfer(0, 1'b1, 4, 32'h0000_0001, 4'hF, rd, ack, err, lat);
        m_stat[0] = 1'b1;
        bus_xfer(0, 1'b0, 4, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_stat || irq_a !== 1'b1)
            $display("FAIL set_beats_w1c: stat=%h irq=%b required stat=%h irq=1", rd, irq_a, m_stat);
        else n_pass++;
        bus_xfer(0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF, rd, ack, err, lat); model_write(4, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic test_falling();
        logic [31:0] rd; logic ack, err; int lat;
        bus_xfer(0, 1'b1, 5, 32'd0, 4'hF, rd, ack, err, lat); model_write(5, 32'd0, 4'hF);
        settle_gpio(m_gpio | 32'h8);
        bus_xfer(0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF, rd, ack, err, lat); model_write(4, 32'hFFFF_FFFF, 4'hF);
        settle_gpio(m_gpio & ~32'h8);
        bus_xfer(0, 1'b0, 4, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_stat || rd[3] !== 1'b1)
            $display("FAIL falling_set: stat=%h required %h", rd, m_stat);
        else n_pass++;
        bus_xfer(0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF, rd, ack, err, lat); model_write(4, 32'hFFFF_FFFF, 4'hF);
        settle_gpio(m_gpio | 32'h8);
        bus_xfer(0, 1'b0, 4, 32'd0, 4'h0, rd, ack, err, lat);
        n_checks++;
        if (rd !== m_stat) $display("FAIL rise_ignored_when_falling: stat=%h required %h", rd, m_stat);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic ack, err; int lat, op, idx; logic [3:0] sel;
        for (int it = 0; it < 60; it++) begin
            op  = $urandom_range(0, 4);
            d   = $urandom();
            sel = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    idx = $urandom_range(1, 5);
                    bus_xfer(0, 1'b1, idx, d, sel, rd, ack, err, lat);
                    model_write(idx, d, sel);
                    n_checks++;
                    if (ack !== 1'b1 || err !== 1'b0 || gpo_a !== m_dout || oe_a !== m_dir ||
                        irq_a !== |(m_stat & m_en))
                        $display("FAIL rand_write idx=%0d: ack=%b err=%b gpo=%h oe=%h irq=%b required ack=1 err=0 gpo=%h oe=%h irq=%b",
                                 idx, ack, err, gpo_a, oe_a, irq_a, m_dout, m_dir, |(m_stat & m_en));
                    else n_pass++;
                end
                1: begin
                    idx = $urandom_range(0, 5);
                    bus_xfer(0, 1'b0, idx, d, sel, rd, ack, err, lat);
                    n_checks++;
                    if (rd !== model_read(idx) || ack !== 1'b1)
                        $display("FAIL rand_read idx=%0d: got %h ack=%b required %h ack=1",
                                 idx, rd, ack, model_read(idx));
                    else n_pass++;
                end
                2: begin
                    settle_gpio(m_gpio ^ (32'h1 << $urandom_range(0, 31)) ^ (32'h1 << $urandom_range(0, 31)));
                    n_checks++;
                    if (irq_a !== |(m_stat & m_en))
                        $display("FAIL rand_irq: got %b required %b (stat model %h)", irq_a, |(m_stat & m_en), m_stat);
                    else n_pass++;
                end
                3: begin
                    if ($urandom_range(0, 1) == 0)
                        bus_xfer(0, 1'b1, 0, d, sel, rd, ack, err, lat);
                    else
                        bus_xfer(0, 1'($urandom_range(0, 1)), 7, d, sel, rd, ack, err, lat);
                    n_checks++;
                    if (ack !== 1'b0 || err !== 1'b1 || rd !== 32'd0 || gpo_a !== m_dout)
                        $display("FAIL rand_err: ack=%b err=%b dat=%h gpo=%h required ack=0 err=1 dat=0 gpo=%h",
                                 ack, err, rd, gpo_a, m_dout);
                    else n_pass++;
                end
                default: begin
                    bus_xfer(0, 1'b1, 6, d, sel, rd, ack, err, lat);
`ifdef WB_GPIO_TOGGLE_EN
                    model_write(6, d, sel);
                    n_checks++;
                    if (ack !== 1'b1 || gpo_a !== m_dout)
                        $display("FAIL rand_toggle: ack=%b gpo=%h required ack=1 gpo=%h", ack, gpo_a, m_dout);
                    else n_pass++;
`else
                    n_checks++;
                    if (err !== 1'b1 || gpo_a !== m_dout)
                        $display("FAIL rand_idx6: err=%b gpo=%h required err=1 gpo=%h", err, gpo_a, m_dout);
                    else n_pass++;
`endif
                end
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_lanes();
        test_dir_err();
        test_irq_rise();
        test_falling();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
